rr_arbiter: RTL
===============

Name: rr_arbiter

Overview:
- Round-robin arbiter sharing one resource among 16 requesters.
- Wraps a lowest-index-first priority resolver with a rotating priority pointer, a registered one-hot grant and a release handshake.
- Sits between the requesting engines and the shared datapath. Its one-hot grant drives that datapath's select.

Parameters:
- NUM_REQ, 16, number of requesters. Fixed at 16 in this revision.
- IDX_W, 4, width of the grant index. Equals log2(NUM_REQ).
- MAX_HOLD, 64, maximum cycles a grant may be held. Used only with HOLD_TIMEOUT_EN; legal range 2..255.

Ports:
- clkPort  in  1  system clock; all logic on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- requestSignals  in  16  level requests; bit i high = requester i wants or holds the resource.
- grantSignals  out  16  registered one-hot grant; all zero when idle.
- grantValid  out  1  high when any grant bit is high.
- grantIndex  out  4  binary index of the current grantee; holds last value when idle.
- timeoutPulse  out  1  one-cycle pulse when a grant is revoked by timeout.

Behaviour:
- Interface decision: one clock, clkPort; Reset is synchronous and active-high.
- Reset (sampled on a clkPort edge) clears: grantSignals=0, grantValid=0, grantIndex=0, timeoutPulse=0, pointer=0, holdCount=0, state=IDLE.
- Reset asserted mid-grant revokes the grant on that same edge. No release cycle is inserted.
- States:
  - IDLE: no grant.
  - GRANT: grantSignals one-hot, held.
  - RELEASE: one dead cycle with grantSignals=0 to guarantee break-before-make.
- Selection, combinational:
  - masked = requestSignals with bits below pointer cleared.
  - If masked is nonzero, winner = lowest set bit of masked; otherwise winner = lowest set bit of requestSignals.
- IDLE -> GRANT:
  - Taken when requestSignals != 0.
  - grantSignals, grantIndex and grantValid load the winner on that edge, so latency is 1 cycle from request to grant.
- GRANT stays while requestSignals[grantIndex]=1. Other requests are ignored and no preemption occurs.
- GRANT -> RELEASE when requestSignals[grantIndex]=0. On that edge:
  - grantSignals=0 and grantValid=0.
  - pointer = grantIndex+1 mod 16; after index 15 the pointer wraps to 0.
- RELEASE -> IDLE unconditionally.
  - Requests present during RELEASE are arbitrated in IDLE.
  - Minimum spacing between consecutive grants is therefore 2 idle cycles.
- A request dropped and reraised by a non-grantee has no effect.
- A grantee that releases and immediately re-requests loses priority to any other pending requester.
- pointer changes only on release, timeout or Reset.
- timeoutPulse is 0 at all times when the timeout logic is absent.

Optional Feature:
- Macro: HOLD_TIMEOUT_EN.
- With the macro defined:
  - An 8-bit holdCount clears on entry to GRANT and increments each GRANT cycle.
  - When holdCount = MAX_HOLD-1 and the request is still high, the arbiter goes to RELEASE as a normal release would, with the pointer advanced past the grantee.
  - timeoutPulse=1 for that one cycle.
  - The total grant is therefore exactly MAX_HOLD cycles.
- Without the macro: the counter is absent, the grant is held indefinitely, and timeoutPulse is tied 0.

Decomposition:
- Package arb_pkg holds:
  - NUM_REQ and IDX_W.
  - The state encoding (IDLE=2'd0, GRANT=2'd1, RELEASE=2'd2).
  - A function converting a one-hot vector to an index.
- Sub-module lsb_priority_select: a combinational 16-bit lowest-set-bit one-hot selector, with zero output for zero input.
  - Instantiated twice, once for the masked vector and once for the unmasked vector.

Test Plan:
- Reset, then requestSignals=16'h0001 -> next edge: grantSignals=16'h0001, grantIndex=0, grantValid=1. After release the pointer is 1.
- requestSignals=16'h8001 with pointer=1 -> grant bit 15. Drop bit 15 -> RELEASE, then IDLE, then grant bit 0; pointer wraps to 0 after bit 15.
- All 16 requesters held high, each releasing after 3 grant cycles -> grants visit 0,1,…,15,0 in order, with 2 zero-grant cycles between grants.
- Reset asserted while grantIndex=5 is held -> the next edge gives grantSignals=0 and pointer=0. Any request then arbitrates from index 0.
- HOLD_TIMEOUT_EN, MAX_HOLD=4, bit 3 held high, bit 7 pending -> bit 3 is granted exactly 4 cycles, timeoutPulse fires once, then bit 7 is granted.
- Non-grantee bit 9 toggled every cycle while bit 2 holds the grant -> grantSignals stays 16'h0004 throughout.

Source files
------------

// File: rtl/rr_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter: sizes, FSM encoding and a
// one-hot to binary index helper.
package arb_pkg;

    localparam int NUM_REQ = 16;
    localparam int IDX_W   = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_e;

    // An all-zero input maps to index 0.
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] onehot);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (onehot[i]) idx |= IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter_lsb_priority_select.sv
// Combinational lowest-set-bit selector: one-hot output, zero for zero input.
module lsb_priority_select
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] sel_o
);

    // Two's complement isolates the lowest set bit without a priority chain.
    assign sel_o = req_i & (~req_i + NUM_REQ'(1));

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter for 16 requesters with registered one-hot grant and a
// break-before-make release cycle. Define HOLD_TIMEOUT_EN to bound grant length.
module rr_arbiter
    import arb_pkg::*;
`ifdef HOLD_TIMEOUT_EN
#(
    parameter int unsigned MAX_HOLD = 64
)
`endif
(
    input  logic               clkPort,
    input  logic               Reset,
    input  logic [NUM_REQ-1:0] requestSignals,
    output logic [NUM_REQ-1:0] grantSignals,
    output logic               grantValid,
    output logic [IDX_W-1:0]   grantIndex,
    output logic               timeoutPulse
);

    state_e             state_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [IDX_W-1:0]   index_q;
    logic [IDX_W-1:0]   ptr_q;
    logic               valid_q;

    logic [NUM_REQ-1:0] masked_req;
    logic [NUM_REQ-1:0] masked_sel;
    logic [NUM_REQ-1:0] raw_sel;
    logic [NUM_REQ-1:0] grant_d;
    logic               hold_expired;

    assign masked_req = requestSignals & ~((NUM_REQ'(1) << ptr_q) - NUM_REQ'(1));

    lsb_priority_select u_sel_masked (
        .req_i (masked_req),
        .sel_o (masked_sel)
    );

    lsb_priority_select u_sel_raw (
        .req_i (requestSignals),
        .sel_o (raw_sel)
    );

    assign grant_d = (|masked_req) ? masked_sel : raw_sel;

`ifdef HOLD_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0] hold_q;
    logic       timeout_q;

    assign hold_expired = (hold_q == HOLD_LAST);
    assign timeoutPulse = timeout_q;
`else
    assign hold_expired = 1'b0;
    assign timeoutPulse = 1'b0;
`endif

    // NOTE: every register here uses <= so all state updates see the
    // pre-edge values, regardless of statement order within the block.
    always_ff @(posedge clkPort) begin
        if (Reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            index_q <= '0;
            ptr_q   <= '0;
            valid_q <= 1'b0;
`ifdef HOLD_TIMEOUT_EN
            hold_q    <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
`ifdef HOLD_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (|requestSignals) begin
                        state_q <= GRANT;
                        grant_q <= grant_d;
                        index_q <= onehot_to_idx(grant_d);
                        valid_q <= 1'b1;
`ifdef HOLD_TIMEOUT_EN
                        hold_q  <= '0;
`endif
                    end
                end
                GRANT: begin
                    // A timeout is a release forced while the request is still up.
                    if (!requestSignals[index_q] || hold_expired) begin
                        state_q <= RELEASE;
                        grant_q <= '0;
                        valid_q <= 1'b0;
                        ptr_q   <= index_q + IDX_W'(1);
`ifdef HOLD_TIMEOUT_EN
                        timeout_q <= requestSignals[index_q];
`endif
                    end
`ifdef HOLD_TIMEOUT_EN
                    else begin
                        hold_q <= hold_q + 8'd1;
                    end
`endif
                end
                RELEASE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign grantSignals = grant_q;
    assign grantValid   = valid_q;
    assign grantIndex   = index_q;

endmodule
